nios_core_key_irq: RTL and testbench
====================================

# nios_core_key_irq

Parametrised key/button input port for the Nios II core's Avalon-MM peripheral bus. Synchronises and debounces each of WIDTH key inputs independently, captures the selected edge type in a sticky register, and raises a level interrupt filtered by a software-writable mask. It is the interrupt-capable successor to the plain polled key input port. It keeps the same 1-cycle registered read and address-0 data register, and adds mask and edge-capture registers plus an `irq` output.

## Interface
- `WIDTH`, 4: number of key inputs, 1..32.
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronised input must differ from the debounced value before it is accepted; minimum 1.
- `EDGE_TYPE`, 1: debounced edge that sets capture: 0 rising, 1 falling, 2 either.
- `IDLE_LEVEL`, {WIDTH{1'b1}}: reset value of both synchroniser stages and the debounced value (keys idle high).
- `clk`  in  1  system clock; everything on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `address`  in  2  Avalon word address.
- `chipselect`  in  1  slave select, qualifies writes.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; bits [WIDTH-1:0] used.
- `in_port`  in  WIDTH  raw asynchronous key inputs.
- `readdata`  out  32  registered read data, zero-extended above WIDTH.
- `irq`  out  1  level interrupt, high while any unmasked capture bit is set.

## Operation
- Synchroniser: two flops per bit, `in_port` → s1 → s2. Reset value is IDLE_LEVEL.
- Debounce, per bit i, with counter `cnt[i]` of width clog2(DEBOUNCE_CYCLES)+1:
  - If s2[i] == stable[i]: `cnt[i]` <= 0.
  - Else if `cnt[i]` == DEBOUNCE_CYCLES-1: stable[i] <= s2[i] and `cnt[i]` <= 0. This is an accepted transition.
  - Else: `cnt[i]` increments.
  - A glitch shorter than DEBOUNCE_CYCLES returns the counter to 0 and is never accepted.
- Edge event, per bit: an accepted transition matching EDGE_TYPE.
  - Rising: 0→1. Falling: 1→0. Either: both.
  - The event is decided from the transition condition, not from a delayed copy of stable.
- Register map. A write happens on a cycle with `chipselect`=1 and `write_n`=0.
  - 0 data: read-only, returns stable. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 interruptmask: read/write `mask[WIDTH-1:0]`.
  - 3 edgecapture: read returns capture. Writing 1 to a bit clears that bit (write-1-to-clear); writing 0 leaves it unchanged.
- Capture update each cycle: capture <= (capture & ~clr) | event.
  - clr is `writedata[WIDTH-1:0]` when a write to address 3 occurs, else 0.
  - An event and a clear on the same bit in the same cycle leave the bit set (set wins).
- `irq` = |(capture & mask). It is combinational from registers only, so it is glitch-free.
- `readdata` <= zero-extend of mux(address) every cycle, independent of `chipselect`. Address 1 and unused upper bits give 0.
- Reset (`reset_n`=0 at a clock edge):
  - s1, s2 and stable go to IDLE_LEVEL; cnt, mask, capture and `readdata` go to 0; `irq` = 0.
  - Reset mid-debounce discards the pending transition.
  - Reset overrides a simultaneous write.

## Timing
- Read latency is 1 cycle: `readdata` reflects the address presented at edge n after edge n. No wait states.
- Write takes effect at the edge on which it is presented. A read of the same register at the next address cycle sees the new value.
- Input to capture: an `in_port` change first sampled by s1 at edge k updates stable and capture at edge k+1+DEBOUNCE_CYCLES.
  - `irq` (if unmasked) is high after that edge.
  - The capture is visible on `readdata` one edge later.
- Mask write to 1 with capture already set: `irq` high immediately after the write edge.
- Clear of the last unmasked set bit: `irq` low immediately after the write edge, unless a new event arrives in the same cycle.
- Input toggling every cycle never yields an accepted transition.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `in_port`=4'b0000. Required: `readdata`=0 and `irq`=0. Address 0 reads 4'b1111 until 2+DEBOUNCE_CYCLES cycles after release, then 4'b0000. The mask is 0, so `irq` stays 0.
- Debounced falling edge, WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, mask=4'b0010: drive bit1 low and hold.
  - Required: capture=4'b0010 and `irq`=1 exactly 5 edges after first s1 sample.
  - Address 3 read returns 32'h2.
- Glitch rejection: pulse bit0 low for DEBOUNCE_CYCLES-1 cycles. Required: stable, capture and `irq` unchanged. Then hold it low for DEBOUNCE_CYCLES cycles; required: capture bit0 sets.
- W1C and collision:
  - Write 32'h3 to address 3 with capture=4'b0011. Required: capture=0 and `irq`=0 next cycle.
  - Repeat with a bit1 accepted transition on the same edge. Required: capture=4'b0010.
- Mask gating: capture=4'b1000 with mask=0 gives `irq`=0. Write mask=4'b1000: `irq`=1 after that edge. Read address 2 returns 32'h8.
- EDGE_TYPE=2 with WIDTH=1: a press then a release, each held DEBOUNCE_CYCLES cycles, each set capture. Clearing between them re-sets the bit on the release.

Source files
------------

// File: rtl/nios_core_key_irq.sv
// Key/button input port for the Avalon-MM peripheral bus.
// Each key is synchronised and debounced on its own. The selected debounced edge
// sets a sticky capture bit. A level interrupt is raised while any capture bit
// that software has unmasked is set.
module nios_core_key_irq #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               EDGE_TYPE       = 1,   // 0 rising, 1 falling, 2 either
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } addr_e;

    addr_e             addr;
    logic              wr_en;
    logic [31:0]       unused_writedata;

    logic [WIDTH-1:0]  s1_q, s2_q;
    logic [WIDTH-1:0]  stable_q, stable_d;
    logic [CW-1:0]     cnt_q [WIDTH];
    logic [CW-1:0]     cnt_d [WIDTH];
    logic [WIDTH-1:0]  edge_evt;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  capture_q, capture_d;
    logic [WIDTH-1:0]  clr;
    logic [31:0]       readdata_q, readdata_d;

    assign addr             = addr_e'(address);
    assign wr_en            = chipselect && !write_n;
    // Only the low WIDTH bits carry register contents; the rest is ignored.
    assign unused_writedata = writedata;

    // Debounce: count consecutive cycles the synchronised input disagrees with
    // the debounced value; accept the new level once the count completes.
    // The edge event comes from the acceptance itself, so it is aligned with
    // the stable update rather than lagging it by a cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        stable_d = stable_q;
        edge_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                    edge_evt[i] = (EDGE_TYPE == 2) || (s2_q[i] == (EDGE_TYPE == 0));
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Register writes: mask is plain read/write, edge capture is write-1-to-clear
    // with a same-cycle event winning over the clear.
    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && addr == ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && addr == ADDR_EDGE) begin
            clr = writedata[WIDTH-1:0];
        end
        capture_d = (capture_q & ~clr) | edge_evt;
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (addr)
            ADDR_DATA: readdata_d[WIDTH-1:0] = stable_q;
            ADDR_RSVD: readdata_d            = '0;
            ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = capture_q;
            default:   readdata_d            = '0;
        endcase
    end

    // State registers with synchronous active-low reset; reset wins over any write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            s1_q       <= IDLE_LEVEL;
            s2_q       <= IDLE_LEVEL;
            stable_q   <= IDLE_LEVEL;
            mask_q     <= '0;
            capture_q  <= '0;
            readdata_q <= '0;
            // NOTE: the counter array is reset on purpose so a pending transition is discarded by reset.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            capture_q  <= capture_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & mask_q);

endmodule

// File: tb/tb_nios_core_key_irq.sv
// Scoreboard bench for nios_core_key_irq.
// Stimulus issues reads and pushes the hand-computed response; a monitor pops
// and compares one cycle later when the registered read data is valid.
module tb_nios_core_key_irq;

    localparam bit DUT_A = 1'b0;   // WIDTH=4, falling edge
    localparam bit DUT_B = 1'b1;   // WIDTH=1, either edge

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_a;
    logic [0:0]  in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    logic        rd_req;
    logic        rd_valid_q = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          which;
        logic [31:0] rd;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    nios_core_key_irq #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(4'b1111)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    nios_core_key_irq #(
        .WIDTH(1), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit which, input logic [31:0] rdv, input logic irqv,
                            input string nm);
        exp_t e;
        e.which = which;
        e.rd    = rdv;
        e.irq   = irqv;
        e.name  = nm;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a read for one edge and record what must come back after it.
    task automatic rd(input bit which, input logic [1:0] a, input logic [31:0] rdv,
                      input logic irqv, input string nm);
        address = a;
        rd_req  = 1'b1;
        push_exp(which, rdv, irqv, nm);
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Write and read the same address on one edge: read data shows the
    // pre-write value, irq shows the state right after the write edge.
    task automatic wr_rd(input bit which, input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] rdv, input logic irqv, input string nm);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        rd_req     = 1'b1;
        push_exp(which, rdv, irqv, nm);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_req     = 1'b0;
    endtask

    // Read-valid strobe: a read presented at one edge has data after that edge.
    always @(posedge clk) rd_valid_q <= rd_req;

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (rd_valid_q) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got a read with no expectation queued (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.which == DUT_B) begin
                    check({mon_e.name, ".readdata"}, rd_b, mon_e.rd);
                    check({mon_e.name, ".irq"}, {31'b0, irq_b}, {31'b0, mon_e.irq});
                end else begin
                    check({mon_e.name, ".readdata"}, rd_a, mon_e.rd);
                    check({mon_e.name, ".irq"}, {31'b0, irq_a}, {31'b0, mon_e.irq});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_a       = 4'b0000;
        in_b       = 1'b1;
        rd_req     = 1'b0;

        // Reset held for three edges; the third carries a read.
        cyc(2);
        rd(DUT_A, 2'd0, 32'h0, 1'b0, "reset_rd");
        reset_n = 1'b1;

        // Keys held low since reset: data reads 1111 until the fall is accepted.
        for (int i = 0; i < 7; i++) begin
            rd(DUT_A, 2'd0, (i < 6) ? 32'hF : 32'h0, 1'b0, $sformatf("post_reset_data%0d", i));
        end

        // All four bits fell, so capture is full but mask is 0.
        in_a = 4'b1111;
        rd(DUT_A, 2'd3, 32'hF, 1'b0, "cap_after_reset");
        wr_rd(DUT_A, 2'd3, 32'hF, 32'hF, 1'b0, "w1c_all");
        rd(DUT_A, 2'd3, 32'h0, 1'b0, "cap_cleared");
        rd(DUT_A, 2'd1, 32'h0, 1'b0, "reserved");
        cyc(8);
        rd(DUT_A, 2'd3, 32'h0, 1'b0, "rise_no_capture");
        rd(DUT_A, 2'd0, 32'hF, 1'b0, "data_idle");

        // Debounced falling edge on bit1 with mask 0010: irq 5 edges after first sample.
        wr(2'd2, 32'h2);
        in_a = 4'b1101;
        for (int j = 0; j < 7; j++) begin
            rd(DUT_A, 2'd3, (j >= 6) ? 32'h2 : 32'h0, (j >= 5), $sformatf("fall_b1_%0d", j));
        end
        rd(DUT_A, 2'd0, 32'hD, 1'b1, "data_after_fall");

        // Glitch of DEBOUNCE_CYCLES-1 on bit0 is rejected.
        in_a = 4'b1100;
        cyc(3);
        in_a = 4'b1101;
        cyc(8);
        rd(DUT_A, 2'd0, 32'hD, 1'b1, "glitch_stable");
        rd(DUT_A, 2'd3, 32'h2, 1'b1, "glitch_cap");

        // Held for DEBOUNCE_CYCLES it is accepted.
        in_a = 4'b1100;
        cyc(4);
        in_a = 4'b1101;
        cyc(12);
        rd(DUT_A, 2'd3, 32'h3, 1'b1, "hold_cap");
        rd(DUT_A, 2'd0, 32'hD, 1'b1, "hold_stable");

        // Write-1-to-clear of both bits: irq drops right after the write edge.
        wr_rd(DUT_A, 2'd3, 32'h3, 32'h3, 1'b0, "w1c_irq");
        rd(DUT_A, 2'd3, 32'h0, 1'b0, "w1c_cap");

        // Rebuild capture 0011, then re-arm bit1 high.
        in_a = 4'b1111;
        cyc(10);
        in_a = 4'b1100;
        cyc(10);
        rd(DUT_A, 2'd3, 32'h3, 1'b1, "recap");
        in_a = 4'b1110;
        cyc(10);
        rd(DUT_A, 2'd0, 32'hE, 1'b1, "rearm_stable");

        // Bit1 fall accepted on the very edge of the clear: set wins.
        in_a = 4'b1100;
        cyc(5);
        wr_rd(DUT_A, 2'd3, 32'h3, 32'h3, 1'b1, "collide_irq");
        rd(DUT_A, 2'd3, 32'h2, 1'b1, "collide_cap");

        // Mask gating on bit3.
        wr(2'd3, 32'hF);
        wr(2'd2, 32'h0);
        in_a = 4'b0100;
        cyc(10);
        rd(DUT_A, 2'd3, 32'h8, 1'b0, "mask_gate_cap");
        wr_rd(DUT_A, 2'd2, 32'h8, 32'h0, 1'b1, "mask_set_irq");
        rd(DUT_A, 2'd2, 32'h8, 1'b1, "mask_rd");

        // Either-edge instance: press and release each capture.
        wr(2'd2, 32'h1);
        in_b = 1'b0;
        cyc(8);
        rd(DUT_B, 2'd3, 32'h1, 1'b1, "b_press");
        rd(DUT_B, 2'd0, 32'h0, 1'b1, "b_data_lo");
        wr_rd(DUT_B, 2'd3, 32'h1, 32'h1, 1'b0, "b_clr");
        in_b = 1'b1;
        cyc(8);
        rd(DUT_B, 2'd3, 32'h1, 1'b1, "b_release");
        rd(DUT_B, 2'd0, 32'h1, 1'b1, "b_data_hi");

        // Reset overrides a simultaneous mask write.
        reset_n = 1'b0;
        wr_rd(DUT_A, 2'd2, 32'hF, 32'h0, 1'b0, "reset_over_write");
        reset_n = 1'b1;
        rd(DUT_A, 2'd2, 32'h0, 1'b0, "mask_after_reset");
        rd(DUT_A, 2'd3, 32'h0, 1'b0, "cap_after_reset2");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
